uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: frames one byte with configurable data length, optional parity and
// one or two stop bits; each serial bit lasts OVERSAMPLE baud_tick pulses.
module uart_tx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       uart_clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [1:0] data_bits,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       stop2,
   output logic       txd,
   output logic       tx_busy
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state;
   state_t          state_next;
   logic [TW-1:0]   tick_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      data_q;
   logic [1:0]      bits_q;
   logic            par_en_q;
   logic            par_odd_q;
   logic            stop2_q;
   logic            accept;
   logic            bit_done;
   logic [2:0]      last_idx;
   logic [7:0]      data_mask;
   logic            parity_bit;

   assign accept     = tx_valid && (state == IDLE);
   assign bit_done   = (state != IDLE) && baud_tick && (tick_cnt == TICK_LAST);
   assign last_idx   = {1'b0, bits_q} + 3'd4;
   assign data_mask  = 8'hFF >> (2'd3 - bits_q);
   assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;
   assign tx_ready   = (state == IDLE);
   assign tx_busy    = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = START;
         START:   if (bit_done) state_next = DATA;
         DATA:    if (bit_done && (bit_cnt == last_idx)) state_next = par_en_q ? PARITY : STOP;
         PARITY:  if (bit_done) state_next = STOP;
         STOP:    if (bit_done && (bit_cnt[0] == stop2_q)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // bit_cnt indexes data bits in DATA and counts stop periods in STOP
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         data_q    <= '0;
         bits_q    <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            data_q    <= tx_data;
            bits_q    <= data_bits;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            stop2_q   <= stop2;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
         end else if ((state != IDLE) && baud_tick) begin
            tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
            if (bit_done) bit_cnt <= (state_next != state) ? 3'd0 : bit_cnt + 3'd1;
         end
      end
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         START:   txd = 1'b0;
         DATA:    txd = data_q[bit_cnt];
         PARITY:  txd = parity_bit;
         default: txd = 1'b1;
      endcase
   end

endmodule
